// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : bit counter width for a given operand width
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Counter only has to reach WIDTH-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full adder built from two half adders and an OR.
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;
   logic g1;
   logic g2;

   // First half adder: x + y
   assign p  = x ^ y;
   assign g1 = x & y;

   // Second half adder: partial sum + carry in
   assign s  = p ^ ci;
   assign g2 = p & ci;

   assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands plus carry-in over a
// valid/ready handshake and adds them LSB-first, one bit per clock, through
// a single full-adder cell. The result is presented over a second
// valid/ready handshake and held until consumed.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum, cout           : (a + b + cin) mod 2^WIDTH and bit WIDTH
//   ovf                 : signed overflow, only when SERIAL_ADDER_OVF_EN
//                         is defined
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned   CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] b_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic             carry_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic             in_ready_nxt;
   logic             out_valid_nxt;
   logic             fa_s;
   logic             fa_co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_nxt;
`endif

   fa_cell u_fa (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Carry flop holds the running carry; after the last bit it is cout.
   assign cout = carry;

   // Next-state and datapath update.
   always_comb begin
      state_nxt = state;
      a_nxt     = a_sr;
      b_nxt     = b_sr;
      sum_nxt   = sum;
      carry_nxt = carry;
      cnt_nxt   = cnt;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_nxt   = ovf;
`endif

      case (state)
         IDLE: begin
            if (in_valid) begin
               a_nxt     = a;
               b_nxt     = b;
               carry_nxt = cin;
               cnt_nxt   = '0;
               sum_nxt   = '0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_nxt   = 1'b0;
`endif
               state_nxt = RUN;
            end
         end
         RUN: begin
            a_nxt     = a_sr >> 1;
            b_nxt     = b_sr >> 1;
            carry_nxt = fa_co;
            sum_nxt   = {fa_s, sum[WIDTH-1:1]};
            if (cnt == LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
               // carry is the carry into the MSB on this last bit
               ovf_nxt   = carry ^ fa_co;
`endif
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Handshake flags registered from the next state.
      in_ready_nxt  = (state_nxt == IDLE);
      out_valid_nxt = (state_nxt == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         sum       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         a_sr      <= a_nxt;
         b_sr      <= b_nxt;
         sum       <= sum_nxt;
         carry     <= carry_nxt;
         cnt       <= cnt_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= ovf_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table,
// backpressure, mid-run reset, reset priority and randomized back-to-back
// traffic against an arithmetic reference model.
module tb_serial_adder;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
   } op_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer addition.
   function automatic logic [WIDTH:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      int unsigned t;
      t = int'(x) + int'(y) + int'(c);
      return 9'(t);
   endfunction

   // Reference: signed result outside the 8-bit two's complement range.
   function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
      int t;
      t = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (t > 127) || (t < -128);
   endfunction

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) check({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
   endtask

   task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [7:0] es, input logic ec, input string nm);
      int lat;
      out_ready = 1'b0;
      wait_ready(nm);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({nm, "_latency"}, 64'(lat), 64'(WIDTH));
      check({nm, "_sum"}, 64'(sum), 64'(es));
      check({nm, "_cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, "_ovf"}, 64'(ovf), 64'(ref_ovf(av, bv, cv)));
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, "_consumed_valid"}, 64'(out_valid), 64'd0);
      check({nm, "_consumed_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      op_t  q[$];
      op_t  e;
      logic [WIDTH:0] r;
      logic acc;
      int   gap;
      int   got;
      bit   seen;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                $sformatf("vec%0d", i));
      end

      // Backpressure: result held, new operands ignored while in DONE
      wait_ready("bp");
      a = 8'h12; b = 8'h34; cin = 1'b1; in_valid = 1'b1;
      tick();
      a = 8'hF0; b = 8'h0F; cin = 1'b0;
      for (int n = 0; n < 40 && !out_valid; n++) tick();
      check("bp_valid_seen", 64'(out_valid), 64'd1);
      for (int n = 0; n < 5; n++) begin
         check("bp_sum_held", 64'(sum), 64'h47);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("bp_consumed_valid", 64'(out_valid), 64'd0);
      check("bp_consumed_ready", 64'(in_ready), 64'd1);
      for (int n = 0; n < 12; n++) tick();
      check("bp_no_extra_result", 64'(out_valid), 64'd0);

      // Reset on the 4th RUN cycle aborts the operation
      wait_ready("mid");
      a = 8'h5A; b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_cout", 64'(cout), 64'd0);
      for (int n = 0; n < 10; n++) tick();
      check("mid_rst_no_result", 64'(out_valid), 64'd0);
      do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "after_rst");

      // Reset wins over a simultaneous accept
      a = 8'h01; b = 8'h01; in_valid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      check("rst_prio_in_ready", 64'(in_ready), 64'd1);
      for (int n = 0; n < 12; n++) tick();
      check("rst_prio_no_result", 64'(out_valid), 64'd0);

      // Random back-to-back traffic; between one-cycle out_valid pulses
      // there are WIDTH+1 low cycles (one IDLE plus WIDTH RUN cycles).
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      out_ready = 1'b1;
      gap = 0; got = 0; seen = 1'b0;
      for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
         acc = in_ready && in_valid;
         if (acc) q.push_back('{a, b, cin});
         tick();
         if (acc) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               check("rand_spurious_valid", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               r = ref_add(e.a, e.b, e.cin);
               check("rand_sum", 64'(sum), 64'(r[WIDTH-1:0]));
               check("rand_cout", 64'(cout), 64'(r[WIDTH]));
`ifdef SERIAL_ADDER_OVF_EN
               check("rand_ovf", 64'(ovf), 64'(ref_ovf(e.a, e.b, e.cin)));
`endif
            end
            if (seen) check("rand_gap", 64'(gap), 64'(WIDTH + 1));
            seen = 1'b1;
            gap = 0;
            got++;
         end else begin
            gap++;
         end
      end
      if (got < 40) check("rand_timeout", 64'(got), 64'd40);
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
